pipe_ctrl: RTL and testbench

- Central hazard/sequencing controller for the Y86-64 5-stage pipeline.
- Drives stall/bubble controls to the F, D, E, M and W pipeline registers.
- Tracks ret drain and exception halt with a small FSM.
- Keeps saturating performance counters (cycles, retired instrs, load-use stalls, mispredicts, rets).

---
 rtl/pipe_ctrl_pkg.sv | 30 +++
 rtl/pipe_ctrl_if.sv | 41 ++++
 rtl/pipe_ctrl_sat_counter.sv | 31 +++
 rtl/pipe_ctrl.sv | 154 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared Y86-64 encodings and controller state type for the pipeline hazard controller.
package pipe_ctrl_pkg;

   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPOPQ   = 4'hB;

   localparam logic [3:0] RNONE   = 4'hF;

   localparam logic [2:0] SAOK    = 3'd1;
   localparam logic [2:0] SHLT    = 3'd2;
   localparam logic [2:0] SADR    = 3'd3;
   localparam logic [2:0] SINS    = 3'd4;

   typedef enum logic [1:0] {
      ST_RUN       = 2'd0,
      ST_RET_DRAIN = 2'd1,
      ST_HALTED    = 2'd2
   } ctrl_state_e;

   // Any status that must stop the machine once it reaches that stage.
   function automatic logic is_exc(input logic [2:0] stat);
      return (stat == SADR) || (stat == SINS) || (stat == SHLT);
   endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline <-> hazard controller bundle: stage status in, register controls and counters out.
interface pipe_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [3:0]       D_icode;
   logic [3:0]       E_icode;
   logic [3:0]       E_dstM;
   logic [3:0]       d_srcA;
   logic [3:0]       d_srcB;
   logic             e_Cnd;
   logic [2:0]       m_stat;
   logic [2:0]       W_stat;
   logic [3:0]       W_icode;

   logic             F_stall;
   logic             D_stall;
   logic             D_bubble;
   logic             E_bubble;
   logic             M_bubble;
   logic             W_stall;
   logic             set_cc_en;
   logic             halted;
   logic [CNT_W-1:0] cyc_cnt;
   logic [CNT_W-1:0] ret_instr_cnt;
   logic [CNT_W-1:0] lu_cnt;
   logic [CNT_W-1:0] mp_cnt;
   logic [CNT_W-1:0] ret_cnt;

   modport master (
      output D_icode, E_icode, E_dstM, d_srcA, d_srcB, e_Cnd, m_stat, W_stat, W_icode,
      input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc_en, halted,
      input  cyc_cnt, ret_instr_cnt, lu_cnt, mp_cnt, ret_cnt
   );

   modport slave (
      input  D_icode, E_icode, E_dstM, d_srcA, d_srcB, e_Cnd, m_stat, W_stat, W_icode,
      output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc_en, halted,
      output cyc_cnt, ret_instr_cnt, lu_cnt, mp_cnt, ret_cnt
   );

endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Event counter that increments by one and sticks at all-ones.
module pipe_ctrl_sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Y86-64 hazard/sequencing controller: stall/bubble generation, ret drain and halt FSM, perf counters.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int CNT_W     = 32,
   parameter int RET_STALL = 3
) (
   input logic        clk,
   input logic        rst_n,
   pipe_ctrl_if.slave bus
);

   localparam int DRAIN_W = (RET_STALL > 2) ? $clog2(RET_STALL) : 1;
   localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(RET_STALL - 1);
   localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(1);

   ctrl_state_e        state_q, state_d;
   logic [DRAIN_W-1:0] drain_q, drain_d;

   logic lu, mp, mexc, wexc, d_is_ret, e_is_opq;
   logic f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall, cc_en, halt;
   logic ret_entry;

   assign lu = ((bus.E_icode == IMRMOVQ) || (bus.E_icode == IPOPQ)) &&
               (bus.E_dstM != RNONE) &&
               ((bus.E_dstM == bus.d_srcA) || (bus.E_dstM == bus.d_srcB));
   assign mp       = (bus.E_icode == IJXX) && !bus.e_Cnd;
   assign mexc     = is_exc(bus.m_stat);
   assign wexc     = is_exc(bus.W_stat);
   assign d_is_ret = (bus.D_icode == IRET);
   assign e_is_opq = (bus.E_icode == IOPQ);

   always_comb begin
      state_d   = state_q;
      drain_d   = drain_q;
      ret_entry = 1'b0;
      f_stall   = 1'b0;
      d_stall   = 1'b0;
      d_bubble  = 1'b0;
      e_bubble  = 1'b0;
      m_bubble  = 1'b0;
      w_stall   = 1'b0;
      cc_en     = 1'b0;
      halt      = 1'b0;

      unique case (state_q)
         ST_RUN: begin
            // A mispredict squashes D, so it beats a load-use hold of D.
            f_stall  = lu || d_is_ret;
            d_stall  = lu && !mp;
            d_bubble = mp || (!lu && d_is_ret);
            e_bubble = mp || lu;
            m_bubble = mexc || wexc;
            w_stall  = wexc;
            cc_en    = e_is_opq && !mexc && !wexc;
            if (wexc) begin
               state_d = ST_HALTED;
            end else if (d_is_ret && !lu && !mp) begin
               state_d   = ST_RET_DRAIN;
               drain_d   = DRAIN_INIT;
               ret_entry = 1'b1;
            end
         end

         ST_RET_DRAIN: begin
            f_stall  = 1'b1;
            d_bubble = 1'b1;
            m_bubble = mexc || wexc;
            w_stall  = wexc;
            cc_en    = e_is_opq && !mexc && !wexc;
            drain_d  = drain_q - 1'b1;
            if (wexc) begin
               state_d = ST_HALTED;
               drain_d = '0;
            end else if (drain_q == DRAIN_LAST) begin
               state_d = ST_RUN;
            end
         end

         ST_HALTED: begin
            f_stall  = 1'b1;
            d_stall  = 1'b1;
            w_stall  = 1'b1;
            e_bubble = 1'b1;
            m_bubble = 1'b1;
            halt     = 1'b1;
         end

         default: begin
            state_d = ST_RUN;
            drain_d = '0;
         end
      endcase

      // Outputs are combinational, so the reset pattern must be forced here too.
      if (!rst_n) begin
         f_stall  = 1'b1;
         d_stall  = 1'b0;
         d_bubble = 1'b1;
         e_bubble = 1'b1;
         m_bubble = 1'b1;
         w_stall  = 1'b0;
         cc_en    = 1'b0;
         halt     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
      end
   end

   assign bus.F_stall   = f_stall;
   assign bus.D_stall   = d_stall;
   assign bus.D_bubble  = d_bubble;
   assign bus.E_bubble  = e_bubble;
   assign bus.M_bubble  = m_bubble;
   assign bus.W_stall   = w_stall;
   assign bus.set_cc_en = cc_en;
   assign bus.halted    = halt;

   logic cyc_inc, ri_inc, lu_inc, mp_inc;

   assign cyc_inc = (state_q != ST_HALTED);
   assign ri_inc  = (bus.W_stat == SAOK) && (bus.W_icode != INOP) && !w_stall;
   assign lu_inc  = (state_q == ST_RUN) && lu;
   assign mp_inc  = (state_q == ST_RUN) && mp;

   pipe_ctrl_sat_counter #(.W(CNT_W)) u_cyc_cnt (
      .clk(clk), .rst_n(rst_n), .inc_i(cyc_inc), .cnt_o(bus.cyc_cnt)
   );

   pipe_ctrl_sat_counter #(.W(CNT_W)) u_ret_instr_cnt (
      .clk(clk), .rst_n(rst_n), .inc_i(ri_inc), .cnt_o(bus.ret_instr_cnt)
   );

   pipe_ctrl_sat_counter #(.W(CNT_W)) u_lu_cnt (
      .clk(clk), .rst_n(rst_n), .inc_i(lu_inc), .cnt_o(bus.lu_cnt)
   );

   pipe_ctrl_sat_counter #(.W(CNT_W)) u_mp_cnt (
      .clk(clk), .rst_n(rst_n), .inc_i(mp_inc), .cnt_o(bus.mp_cnt)
   );

   pipe_ctrl_sat_counter #(.W(CNT_W)) u_ret_cnt (
      .clk(clk), .rst_n(rst_n), .inc_i(ret_entry), .cnt_o(bus.ret_cnt)
   );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus random stimulus against a behavioural model.
module tb_pipe_ctrl;
   import pipe_ctrl_pkg::*;

   localparam int CW   = 4;
   localparam int RS   = 3;
   localparam int CMAX = (1 << CW) - 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pipe_ctrl_if #(.CNT_W(CW)) bus ();

   pipe_ctrl #(.CNT_W(CW), .RET_STALL(RS)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int checks = 0;
   int errors = 0;

   // Model state: halted flag, remaining drain cycles after a ret entry, counters.
   bit m_halt;
   int m_drain;
   int m_cyc, m_ri, m_lu, m_mp, m_ret;

   bit h_lu, h_mp, h_mexc, h_wexc, h_ret;
   bit e_Ws;

   logic s_F, s_Ds, s_Db, s_Eb, s_Mb, s_Ws, s_cc, s_h;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int sat(input int v);
      return (v < CMAX) ? v + 1 : CMAX;
   endfunction

   function automatic bit exc(input logic [2:0] s);
      return (s == 3'd2) || (s == 3'd3) || (s == 3'd4);
   endfunction

   task automatic model_reset();
      m_halt = 0; m_drain = 0;
      m_cyc = 0; m_ri = 0; m_lu = 0; m_mp = 0; m_ret = 0;
   endtask

   task automatic compare();
      bit xF, xDs, xDb, xEb, xMb, xWs, xcc, xh;
      bit draining;
      h_lu   = ((bus.E_icode == 4'd5) || (bus.E_icode == 4'd11)) && (bus.E_dstM != 4'hF) &&
               ((bus.E_dstM == bus.d_srcA) || (bus.E_dstM == bus.d_srcB));
      h_mp   = (bus.E_icode == 4'd7) && !bus.e_Cnd;
      h_mexc = exc(bus.m_stat);
      h_wexc = exc(bus.W_stat);
      h_ret  = (bus.D_icode == 4'd9);
      if (!rst_n) model_reset();
      draining = (m_drain > 0);
      if (!rst_n) begin
         {xF, xDs, xDb, xEb, xMb, xWs, xcc, xh} = 8'b1011_1000;
      end else if (m_halt) begin
         {xF, xDs, xDb, xEb, xMb, xWs, xcc, xh} = 8'b1101_1101;
      end else if (draining) begin
         xF = 1; xDs = 0; xDb = 1; xEb = 0;
         xMb = h_mexc | h_wexc; xWs = h_wexc;
         xcc = (bus.E_icode == 4'd6) && !h_mexc && !h_wexc; xh = 0;
      end else begin
         xF  = h_lu | h_ret;
         xDs = h_lu & !h_mp;
         xDb = h_mp | (!h_lu & h_ret);
         xEb = h_mp | h_lu;
         xMb = h_mexc | h_wexc; xWs = h_wexc;
         xcc = (bus.E_icode == 4'd6) && !h_mexc && !h_wexc; xh = 0;
      end
      e_Ws = xWs;
      s_F = bus.F_stall; s_Ds = bus.D_stall; s_Db = bus.D_bubble; s_Eb = bus.E_bubble;
      s_Mb = bus.M_bubble; s_Ws = bus.W_stall; s_cc = bus.set_cc_en; s_h = bus.halted;
      chk("F_stall", 32'(s_F), 32'(xF));
      chk("D_stall", 32'(s_Ds), 32'(xDs));
      chk("D_bubble", 32'(s_Db), 32'(xDb));
      chk("E_bubble", 32'(s_Eb), 32'(xEb));
      chk("M_bubble", 32'(s_Mb), 32'(xMb));
      chk("W_stall", 32'(s_Ws), 32'(xWs));
      chk("set_cc_en", 32'(s_cc), 32'(xcc));
      chk("halted", 32'(s_h), 32'(xh));
      chk("cyc_cnt", 32'(bus.cyc_cnt), 32'(m_cyc));
      chk("ret_instr_cnt", 32'(bus.ret_instr_cnt), 32'(m_ri));
      chk("lu_cnt", 32'(bus.lu_cnt), 32'(m_lu));
      chk("mp_cnt", 32'(bus.mp_cnt), 32'(m_mp));
      chk("ret_cnt", 32'(bus.ret_cnt), 32'(m_ret));
   endtask

   task automatic advance();
      if (!rst_n) begin
         model_reset();
      end else if (!m_halt) begin
         m_cyc = sat(m_cyc);
         if ((bus.W_stat == 3'd1) && (bus.W_icode != 4'd1) && !e_Ws) m_ri = sat(m_ri);
         if (m_drain == 0) begin
            if (h_lu) m_lu = sat(m_lu);
            if (h_mp) m_mp = sat(m_mp);
         end
         if (h_wexc) begin
            m_halt = 1; m_drain = 0;
         end else if (m_drain > 0) begin
            m_drain--;
         end else if (h_ret && !h_lu && !h_mp) begin
            m_drain = RS - 1;
            m_ret   = sat(m_ret);
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      compare();
      advance();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      bus.D_icode = INOP;  bus.E_icode = INOP;  bus.E_dstM = RNONE;
      bus.d_srcA  = RNONE; bus.d_srcB  = RNONE; bus.e_Cnd  = 1'b1;
      bus.m_stat  = SAOK;  bus.W_stat  = SAOK;  bus.W_icode = INOP;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      set_idle();
      tick();
      rst_n = 1'b1;
   endtask

   function automatic logic [3:0] rnd_icode();
      logic [3:0] tbl [8];
      tbl = '{4'h0, 4'h1, 4'h5, 4'h6, 4'h7, 4'h9, 4'hB, 4'h2};
      return tbl[$urandom_range(0, 7)];
   endfunction

   function automatic logic [3:0] rnd_reg();
      return ($urandom_range(0, 4) == 4) ? 4'hF : 4'($urandom_range(0, 3));
   endfunction

   function automatic logic [2:0] rnd_stat();
      return ($urandom_range(0, 24) == 0) ? 3'($urandom_range(0, 4)) : SAOK;
   endfunction

   initial begin
      int fcount;
      logic [CW-1:0] ri_hold;
      model_reset();
      set_idle();
      rst_n = 1'b0;

      // Reset pattern while rst_n is low.
      tick();
      chk("rst_F_stall_lit", 32'(s_F), 32'd1);
      chk("rst_D_bubble_lit", 32'(s_Db), 32'd1);
      chk("rst_D_stall_lit", 32'(s_Ds), 32'd0);
      rst_n = 1'b1;

      // Idle after reset: controls low, cyc_cnt counts edges.
      for (int i = 0; i < 5; i++) tick();
      chk("idle_cyc_cnt_lit", 32'(bus.cyc_cnt), 32'd5);
      chk("idle_F_stall_lit", 32'(s_F), 32'd0);

      // Load-use hazard.
      do_reset();
      bus.E_icode = IMRMOVQ; bus.E_dstM = 4'd3; bus.d_srcA = 4'd3;
      tick();
      chk("lu_F_stall_lit", 32'(s_F), 32'd1);
      chk("lu_D_stall_lit", 32'(s_Ds), 32'd1);
      chk("lu_E_bubble_lit", 32'(s_Eb), 32'd1);
      chk("lu_D_bubble_lit", 32'(s_Db), 32'd0);
      set_idle();
      tick();
      chk("lu_cnt_lit", 32'(bus.lu_cnt), 32'd1);

      // Ret drain: three fetch-stall cycles in total.
      do_reset();
      bus.D_icode = IRET;
      fcount = 0;
      tick();
      fcount += int'(s_F & s_Db);
      bus.D_icode = INOP;
      for (int i = 0; i < 5; i++) begin
         tick();
         fcount += int'(s_F & s_Db);
      end
      chk("ret_stall_cycles_lit", 32'(fcount), 32'd3);
      chk("ret_cnt_lit", 32'(bus.ret_cnt), 32'd1);

      // Mispredict with ret in D: no drain entry.
      do_reset();
      bus.E_icode = IJXX; bus.e_Cnd = 1'b0; bus.D_icode = IRET;
      tick();
      chk("mp_D_bubble_lit", 32'(s_Db), 32'd1);
      chk("mp_E_bubble_lit", 32'(s_Eb), 32'd1);
      set_idle();
      tick();
      chk("mp_no_drain_lit", 32'(s_F), 32'd0);
      chk("mp_cnt_lit", 32'(bus.mp_cnt), 32'd1);
      chk("mp_ret_cnt_lit", 32'(bus.ret_cnt), 32'd0);

      // Exception in M then W: halt is sticky and freezes counters.
      do_reset();
      bus.W_icode = IOPQ;
      tick();
      bus.m_stat = SADR;
      tick();
      chk("mexc_M_bubble_lit", 32'(s_Mb), 32'd1);
      bus.m_stat = SAOK; bus.W_stat = SADR;
      tick();
      chk("wexc_W_stall_lit", 32'(s_Ws), 32'd1);
      bus.W_stat = SAOK;
      ri_hold = bus.ret_instr_cnt;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("halt_sticky_lit", 32'(s_h), 32'd1);
      end
      chk("halt_ri_frozen", 32'(bus.ret_instr_cnt), 32'(ri_hold));
      do_reset();
      tick();
      chk("halt_cleared_lit", 32'(s_h), 32'd0);

      // Saturation of lu_cnt at all-ones.
      do_reset();
      bus.E_icode = IMRMOVQ; bus.E_dstM = 4'd3; bus.d_srcA = 4'd3;
      for (int i = 0; i < 20; i++) tick();
      chk("lu_sat_lit", 32'(bus.lu_cnt), 32'd15);

      // Random stimulus against the model.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         rst_n       = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
         bus.D_icode = rnd_icode();
         bus.E_icode = rnd_icode();
         bus.E_dstM  = rnd_reg();
         bus.d_srcA  = rnd_reg();
         bus.d_srcB  = rnd_reg();
         bus.e_Cnd   = 1'($urandom_range(0, 1));
         bus.m_stat  = rnd_stat();
         bus.W_stat  = rnd_stat();
         bus.W_icode = rnd_icode();
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
